// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 3-sample majority voting, optional parity and stop-bit checks.
module uart_rx #(
  parameter int Data_WD = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [5:0]         Prescale,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  output logic [Data_WD-1:0] P_DATA,
  output logic               Data_Valid,
  output logic               Par_Err,
  output logic               Stop_Err
);
  localparam int BW = (Data_WD > 1) ? $clog2(Data_WD) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(Data_WD - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  state_e state_q, state_d;
  logic [5:0] edge_q, edge_d, p_q, p_d;
  logic [BW-1:0] bit_q, bit_d;
  logic pen_q, pen_d, ptyp_q, ptyp_d;
  logic [2:0] smp_q, smp_d;
  logic [Data_WD-1:0] data_q, data_d, pd_q, pd_d;
  logic perr_q, perr_d, serr_q, serr_d, done_q, done_d;
  logic dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic [5:0] p_in, half;
  logic is_last, in_win, maj;
  assign p_in = (Prescale == 6'd16 || Prescale == 6'd32) ? Prescale : 6'd8;
  assign half = {1'b0, p_q[5:1]};
  assign is_last = edge_q == p_q - 6'd1;
  assign in_win = edge_q >= half - 6'd1 && edge_q <= half + 6'd1;
  assign maj = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  always_comb begin
    state_d = state_q;
    edge_d = is_last ? '0 : edge_q + 6'd1;
    bit_d = bit_q;
    p_d = p_q;
    pen_d = pen_q;
    ptyp_d = ptyp_q;
    smp_d = in_win ? {smp_q[1:0], RX_IN} : smp_q;
    data_d = data_q;
    perr_d = perr_q;
    serr_d = serr_q;
    done_d = 1'b0;
    // frame verdict is registered one cycle after the stop bit completes
    dv_d = done_q & ~perr_q & ~serr_q;
    pe_d = done_q & perr_q;
    se_d = done_q & serr_q;
    pd_d = dv_d ? data_q : pd_q;
    case (state_q)
      IDLE: begin
        edge_d = '0;
        smp_d = smp_q;
        if (!RX_IN) begin
          state_d = START;
          edge_d = 6'd1;
          p_d = p_in;
          pen_d = PAR_EN;
          ptyp_d = PAR_TYP;
          perr_d = 1'b0;
          serr_d = 1'b0;
        end
      end
      START: if (is_last) state_d = maj ? IDLE : DATA;
      DATA: if (is_last) begin
        data_d[bit_q] = maj;
        bit_d = (bit_q == LAST_BIT) ? '0 : bit_q + 1'b1;
        if (bit_q == LAST_BIT) state_d = pen_q ? PARITY : STOP;
      end
      PARITY: if (is_last) begin
        perr_d = maj ^ (^data_q) ^ ptyp_q;
        state_d = STOP;
      end
      STOP: if (is_last) begin
        serr_d = ~maj;
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      edge_q <= '0;
      bit_q <= '0;
      p_q <= 6'd8;
      pen_q <= 1'b0;
      ptyp_q <= 1'b0;
      smp_q <= '0;
      data_q <= '0;
      perr_q <= 1'b0;
      serr_q <= 1'b0;
      done_q <= 1'b0;
      dv_q <= 1'b0;
      pe_q <= 1'b0;
      se_q <= 1'b0;
      pd_q <= '0;
    end else begin
      state_q <= state_d;
      edge_q <= edge_d;
      bit_q <= bit_d;
      p_q <= p_d;
      pen_q <= pen_d;
      ptyp_q <= ptyp_d;
      smp_q <= smp_d;
      data_q <= data_d;
      perr_q <= perr_d;
      serr_q <= serr_d;
      done_q <= done_d;
      dv_q <= dv_d;
      pe_q <= pe_d;
      se_q <= se_d;
      pd_q <= pd_d;
    end
  end
  assign P_DATA = pd_q;
  assign Data_Valid = dv_q;
  assign Par_Err = pe_q;
  assign Stop_Err = se_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: line-level frame model with expected pulse times derived from frame length arithmetic.
module tb_uart_rx;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic PAR_EN = 1'b0;
  logic PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic Data_Valid, Par_Err, Stop_Err;

  uart_rx #(.Data_WD(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Par_Err(Par_Err),
    .Stop_Err(Stop_Err)
  );

  always #5 CLK = ~CLK;

  typedef struct {int at; bit dv; bit pe; bit se; logic [7:0] d;} ev_t;
  int n_cmp = 0;
  int n_fail = 0;
  bit line_q[$];
  logic [5:0] ps_q[$];
  bit pen_q[$];
  bit typ_q[$];
  ev_t ev_q[$];
  logic dv_log[$];
  logic pe_log[$];
  logic se_log[$];
  logic [7:0] pd_log[$];
  logic [7:0] model_pd = 8'h00;

  function automatic int eff_p(input logic [5:0] ps);
    return (ps == 6'd16 || ps == 6'd32) ? int'(ps) : 8;
  endfunction

  task automatic push_cyc(input bit v, input logic [5:0] ps, input bit pen, input bit typ);
    line_q.push_back(v);
    ps_q.push_back(ps);
    pen_q.push_back(pen);
    typ_q.push_back(typ);
  endtask

  // configuration outside the start-detect cycle is garbage the receiver must ignore
  task automatic push_bit(input bit v, input int n);
    for (int i = 0; i < n; i++) push_cyc(v, 6'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic add_idle(input int n);
    push_bit(1'b1, n);
  endtask

  task automatic add_frame(input logic [7:0] d, input logic [5:0] ps, input bit pen,
                           input bit typ, input bit pflip, input bit stopv);
    int p, s;
    ev_t e;
    p = eff_p(ps);
    s = line_q.size();
    push_cyc(1'b0, ps, pen, typ);
    push_bit(1'b0, p - 1);
    for (int k = 0; k < 8; k++) push_bit(d[k], p);
    if (pen) push_bit((^d) ^ typ ^ pflip, p);
    push_bit(stopv, p);
    e.at = s + (10 + int'(pen)) * p;
    e.pe = pen & pflip;
    e.se = !stopv;
    e.dv = !e.pe && !e.se;
    e.d = e.dv ? d : model_pd;
    model_pd = e.d;
    ev_q.push_back(e);
  endtask

  task automatic add_glitch(input int g, input logic [5:0] ps);
    push_cyc(1'b0, ps, 1'($urandom), 1'($urandom));
    push_bit(1'b0, g - 1);
    push_bit(1'b1, eff_p(ps));
  endtask

  task automatic run_and_check(input string name);
    int npulse;
    ev_t e;
    dv_log.delete(); pe_log.delete(); se_log.delete(); pd_log.delete();
    for (int n = 0; n < line_q.size(); n++) begin
      @(negedge CLK);
      if (n > 0) begin
        dv_log.push_back(Data_Valid); pe_log.push_back(Par_Err);
        se_log.push_back(Stop_Err); pd_log.push_back(P_DATA);
      end
      RX_IN = line_q[n];
      Prescale = ps_q[n];
      PAR_EN = pen_q[n];
      PAR_TYP = typ_q[n];
    end
    @(negedge CLK);
    dv_log.push_back(Data_Valid); pe_log.push_back(Par_Err);
    se_log.push_back(Stop_Err); pd_log.push_back(P_DATA);
    RX_IN = 1'b1;
    foreach (ev_q[j]) begin
      e = ev_q[j];
      n_cmp++;
      if (e.at >= dv_log.size()) begin
        n_fail++;
        $display("FAIL %s ev%0d beyond run: at %0d, log %0d", name, j, e.at, dv_log.size());
      end else begin
        if ({dv_log[e.at], pe_log[e.at], se_log[e.at]} !== {e.dv, e.pe, e.se}) begin
          n_fail++;
          $display("FAIL %s ev%0d flags dv/pe/se got %b%b%b want %b%b%b", name, j,
                   dv_log[e.at], pe_log[e.at], se_log[e.at], e.dv, e.pe, e.se);
        end
        n_cmp++;
        if (pd_log[e.at] !== e.d) begin
          n_fail++;
          $display("FAIL %s ev%0d P_DATA got %h want %h", name, j, pd_log[e.at], e.d);
        end
        n_cmp++;
        if ({dv_log[e.at-1], pe_log[e.at-1], se_log[e.at-1]} !== 3'b000) begin
          n_fail++;
          $display("FAIL %s ev%0d early pulse got %b%b%b want 000", name, j,
                   dv_log[e.at-1], pe_log[e.at-1], se_log[e.at-1]);
        end
      end
    end
    npulse = 0;
    foreach (dv_log[i]) if (dv_log[i] === 1'b1 || pe_log[i] === 1'b1 || se_log[i] === 1'b1) npulse++;
    n_cmp++;
    if (npulse != ev_q.size()) begin
      n_fail++;
      $display("FAIL %s pulse count got %0d want %0d", name, npulse, ev_q.size());
    end
    line_q.delete(); ps_q.delete(); pen_q.delete(); typ_q.delete(); ev_q.delete();
  endtask

  task automatic test_reset;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({Data_Valid, Par_Err, Stop_Err, P_DATA} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset outputs got %b%b%b %h want 000 00", Data_Valid, Par_Err, Stop_Err, P_DATA);
    end
    RST = 1'b1;
    model_pd = 8'h00;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_no_parity;
    add_idle(2); add_frame(8'hAA, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1); add_idle(4);
    run_and_check("no_parity");
  endtask

  task automatic test_even_parity;
    add_idle(2); add_frame(8'hBA, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1); add_idle(4);
    run_and_check("even_parity");
  endtask

  task automatic test_parity_err;
    add_idle(2); add_frame(8'hA6, 6'd8, 1'b1, 1'b1, 1'b1, 1'b1); add_idle(4);
    run_and_check("parity_err");
  endtask

  task automatic test_stop_err;
    add_idle(2);
    add_frame(8'($urandom), 6'd16, 1'b0, 1'b0, 1'b0, 1'b0);
    add_frame(8'h5A, 6'd16, 1'b0, 1'b0, 1'b0, 1'b1);
    add_idle(4);
    run_and_check("stop_err");
  endtask

  task automatic test_break;
    add_idle(2);
    add_frame(8'h33, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    add_frame(8'h00, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    add_idle(10);
    add_frame(8'h81, 6'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    add_idle(4);
    run_and_check("break");
  endtask

  task automatic test_false_start;
    add_idle(2); add_glitch(4, 6'd16);
    add_frame(8'h96, 6'd16, 1'b1, 1'b1, 1'b0, 1'b1); add_idle(4);
    run_and_check("false_start");
  endtask

  task automatic test_back_to_back;
    int first, second;
    add_idle(2);
    add_frame(8'h3C, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1);
    add_frame(8'hC3, 6'd32, 1'b0, 1'b0, 1'b0, 1'b1);
    add_idle(4);
    run_and_check("back_to_back");
    first = -1;
    second = -1;
    foreach (dv_log[i]) if (dv_log[i] === 1'b1) begin
      if (first < 0) first = i;
      else if (second < 0) second = i;
    end
    n_cmp++;
    if (second - first != 320) begin
      n_fail++;
      $display("FAIL back_to_back spacing got %0d want 320", second - first);
    end
  endtask

  task automatic test_random;
    logic [5:0] ps;
    for (int b = 0; b < 6; b++) begin
      add_idle(2);
      for (int f = 0; f < 7; f++) begin
        case ($urandom_range(0, 3))
          0: ps = 6'd8;
          1: ps = 6'd16;
          2: ps = 6'd32;
          default: ps = 6'($urandom_range(0, 63));
        endcase
        if ($urandom_range(0, 5) == 0) add_glitch($urandom_range(1, eff_p(ps) / 2 - 1), ps);
        add_frame(8'($urandom), ps, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0);
        if ($urandom_range(0, 1) == 1) add_idle($urandom_range(1, 3));
      end
      add_idle(4);
      run_and_check("random");
    end
  endtask

  task automatic test_reset_mid_frame;
    @(negedge CLK);
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0; RX_IN = 1'b0;
    repeat (16) @(negedge CLK);
    for (int i = 0; i < 40; i++) begin
      RX_IN = 1'($urandom);
      @(negedge CLK);
    end
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({Data_Valid, Par_Err, Stop_Err, P_DATA} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_mid_frame outputs got %b%b%b %h want 000 00", Data_Valid, Par_Err, Stop_Err, P_DATA);
    end
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    model_pd = 8'h00;
    add_idle(3); add_frame(8'hC5, 6'd16, 1'b1, 1'b0, 1'b0, 1'b1); add_idle(4);
    run_and_check("reset_mid_frame");
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_even_parity();
    test_parity_err();
    test_stop_err();
    test_break();
    test_false_start();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
